// File: rtl/exp_adder_if.sv
// Request/response bundle for the FP multiply exponent adder.
// slave is the adder side, master is the side that drives operands.
interface exp_adder_if #(
    parameter int EXP_W = 8
);
    logic                    in_valid;
    logic [EXP_W-1:0]        exp_a;
    logic [EXP_W-1:0]        exp_b;
    logic                    norm_inc;
    logic signed [EXP_W:0]   res;
    logic [EXP_W-1:0]        exp_out;
    logic                    ovf;
    logic                    unf;
    logic                    zero_in;
    logic                    inf_in;
    logic                    out_valid;

    modport slave (
        input  in_valid, exp_a, exp_b, norm_inc,
        output res, exp_out, ovf, unf, zero_in, inf_in, out_valid
    );

    modport master (
        output in_valid, exp_a, exp_b, norm_inc,
        input  res, exp_out, ovf, unf, zero_in, inf_in, out_valid
    );
endinterface

// File: rtl/exp_adder.sv
// Exponent adder for an FP multiplier: a + b - BIAS + norm_inc.
// The result is saturated at the top only, with ovf/unf and special-operand
// flags. There is one register stage, and data holds while idle.
module exp_adder #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 24
) (
    input  logic            clk,
    input  logic            rst_n,
    exp_adder_if.slave      bus
);
    // Mantissa width only shapes the surrounding datapath. It is folded in
    // with a zero weight so the parameter stays part of the interface.
    localparam int STAGES = 1 + 0 * MANT_W;
    localparam int SW     = EXP_W + 2;
    localparam int BIAS   = (1 << (EXP_W - 1)) - 1;
    localparam int EMAX   = (1 << EXP_W) - 1;

    typedef struct packed {
        logic signed [EXP_W:0] res;
        logic [EXP_W-1:0]      exp_out;
        logic                  ovf;
        logic                  unf;
        logic                  zero_in;
        logic                  inf_in;
    } rsp_t;

    logic signed [SW-1:0] sum;
    rsp_t                 rsp_d;
    rsp_t                 rsp_q;
    logic [STAGES:0]      vld_pipe;

    // Full-width signed sum. At SW bits it never wraps: -BIAS .. 2*EMAX+1-BIAS.
    always_comb begin
        sum = $signed({2'b00, bus.exp_a}) + $signed({2'b00, bus.exp_b})
            - $signed(SW'(BIAS)) + $signed({{(SW-1){1'b0}}, bus.norm_inc});
    end

    // Flags, top saturation and exp_out priority (inf, then ovf, then unf).
    always_comb begin
        rsp_d         = '0;
        rsp_d.ovf     = (sum >= $signed(SW'(EMAX)));
        rsp_d.unf     = (sum <= $signed(SW'(0)));
        rsp_d.zero_in = (bus.exp_a == '0) || (bus.exp_b == '0);
        rsp_d.inf_in  = (&bus.exp_a) || (&bus.exp_b);
        rsp_d.res     = rsp_d.ovf ? $signed((EXP_W+1)'(EMAX)) : sum[EXP_W:0];
        if (rsp_d.inf_in || rsp_d.ovf)
            rsp_d.exp_out = '1;
        else if (rsp_d.unf)
            rsp_d.exp_out = '0;
        else
            rsp_d.exp_out = sum[EXP_W-1:0];
    end

    assign vld_pipe[0] = bus.in_valid;

    // The valid shift register. Reset drops anything in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld_pipe[STAGES:1] <= '0;
        else
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // The result register captures only on valid input and holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rsp_q <= '0;
        else if (bus.in_valid)
            rsp_q <= rsp_d;
    end

    assign bus.res       = rsp_q.res;
    assign bus.exp_out   = rsp_q.exp_out;
    assign bus.ovf       = rsp_q.ovf;
    assign bus.unf       = rsp_q.unf;
    assign bus.zero_in   = rsp_q.zero_in;
    assign bus.inf_in    = rsp_q.inf_in;
    assign bus.out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_exp_adder.sv
// Self-checking bench for exp_adder: directed corner cases, back-to-back
// traffic, random traffic and mid-stream asynchronous reset.
module tb_exp_adder;
    logic clk = 1'b0;
    logic rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    // expected, held state of the outputs
    int e_res, e_eo, e_ovf, e_unf, e_zin, e_iin, e_vld;

    exp_adder_if #(.EXP_W(8)) bus ();

    exp_adder #(.EXP_W(8), .MANT_W(24)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural model using plain integer arithmetic on the exponent rules.
    task automatic model(input int a, input int b, input int n);
        int s;
        s     = a + b - 127 + n;
        e_ovf = (s >= 255) ? 1 : 0;
        e_unf = (s <= 0) ? 1 : 0;
        e_res = (s > 255) ? 255 : s;
        e_zin = (a == 0 || b == 0) ? 1 : 0;
        e_iin = (a == 255 || b == 255) ? 1 : 0;
        if (e_iin == 1 || e_ovf == 1) e_eo = 255;
        else if (e_unf == 1)          e_eo = 0;
        else                          e_eo = s % 256;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".res"},       int'($signed(bus.res)), e_res);
        chk({tag, ".exp_out"},   int'(bus.exp_out),      e_eo);
        chk({tag, ".ovf"},       int'(bus.ovf),          e_ovf);
        chk({tag, ".unf"},       int'(bus.unf),          e_unf);
        chk({tag, ".zero_in"},   int'(bus.zero_in),      e_zin);
        chk({tag, ".inf_in"},    int'(bus.inf_in),       e_iin);
        chk({tag, ".out_valid"}, int'(bus.out_valid),    e_vld);
        chk({tag, ".excl"},      int'(bus.ovf & bus.unf), 0);
    endtask

    task automatic clear_exp();
        e_res = 0; e_eo = 0; e_ovf = 0; e_unf = 0; e_zin = 0; e_iin = 0; e_vld = 0;
    endtask

    // Drive one cycle after the previous edge, then check #1 after the edge.
    task automatic step(input string tag, input bit v, input int a, input int b, input bit n);
        bus.in_valid = v;
        bus.exp_a    = 8'(a);
        bus.exp_b    = 8'(b);
        bus.norm_inc = n;
        @(posedge clk);
        #1;
        if (v) model(a, b, int'(n));
        e_vld = v ? 1 : 0;
        check_all(tag);
    endtask

    int va[7] = '{7, 127, 127, 200, 191, 0, 255};
    int vb[7] = '{33, 127, 127, 200, 191, 130, 1};
    bit vn[7] = '{0, 0, 1, 0, 0, 0, 0};

    initial begin
        clear_exp();
        rst_n        = 1'b0;
        bus.in_valid = 1'b1;
        bus.exp_a    = 8'd150;
        bus.exp_b    = 8'd100;
        bus.norm_inc = 1'b1;
        repeat (2) @(posedge clk);
        #1 check_all("reset_hold");

        @(negedge clk);
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1 check_all("post_reset_idle");

        // directed corners
        for (int i = 0; i < 7; i++)
            step($sformatf("dir%0d", i), 1'b1, va[i], vb[i], vn[i]);
        // explicit spot values from the corner list
        step("dir_m87", 1'b1, 7, 33, 1'b0);
        chk("dir_m87.res_lit", int'($signed(bus.res)), -87);
        step("dir_273", 1'b1, 200, 200, 1'b0);
        chk("dir_273.res_lit", int'($signed(bus.res)), 255);
        step("dir_inf", 1'b1, 255, 1, 1'b0);
        chk("dir_inf.eo_lit", int'(bus.exp_out), 255);
        step("idle_hold", 1'b0, 3, 4, 1'b1);

        // three back-to-back, then idle
        for (int i = 0; i < 3; i++)
            step($sformatf("b2b%0d", i), 1'b1, $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));
        step("b2b_idle", 1'b0, 9, 9, 1'b0);
        step("b2b_idle2", 1'b0, 255, 255, 1'b1);

        // random traffic
        for (int i = 0; i < 300; i++)
            step($sformatf("rnd%0d", i), 1'($urandom_range(0, 3) != 0),
                 $urandom_range(0, 255), $urandom_range(0, 255), 1'($urandom));

        // asynchronous reset between edges while a result is valid
        step("pre_rst", 1'b1, 190, 100, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        clear_exp();
        check_all("async_rst");
        bus.in_valid = 1'b1;
        bus.exp_a    = 8'd140;
        bus.exp_b    = 8'd140;
        @(posedge clk);
        #1 check_all("rst_inputs_dropped");
        @(negedge clk);
        rst_n = 1'b1;
        step("rst_release_idle", 1'b0, 140, 140, 1'b0);
        step("rst_first_cap", 1'b1, 128, 64, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
